// File: rtl/raster_traversal_ctrl.sv
// Triangle setup and traversal controller: fetches three vertices per triangle, culls and
// clips them, then streams the clipped bounding-box raster (optionally after a full clear).
module raster_traversal_ctrl #(
    parameter int SCREEN_W      = 800,
    parameter int SCREEN_H      = 600,
    parameter int COORD_W       = 11,
    parameter int ADDR_W        = 14,
    parameter int ORIGIN_X      = 400,
    parameter int ORIGIN_Y      = 300,
    parameter int VERTEX_STRIDE = 4,
    parameter int COLOR_W       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [31:0]               vertex_count,
    input  logic                      clear_en,
    input  logic [COLOR_W-1:0]        clear_color,
    input  logic [COLOR_W-1:0]        base_color,
    input  logic [1:0]                cull_mode,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic signed [COORD_W-1:0] mem_rdata,
    output logic                      px_valid,
    input  logic                      px_ready,
    output logic signed [COORD_W-1:0] px_x,
    output logic signed [COORD_W-1:0] px_y,
    output logic                      px_clear,
    output logic [COLOR_W-1:0]        px_color,
    output logic signed [COORD_W-1:0] v1_x,
    output logic signed [COORD_W-1:0] v1_y,
    output logic signed [COORD_W-1:0] v2_x,
    output logic signed [COORD_W-1:0] v2_y,
    output logic signed [COORD_W-1:0] v3_x,
    output logic signed [COORD_W-1:0] v3_y,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [15:0]               tri_drawn,
    output logic [15:0]               tri_culled
);

    localparam int TRI_WORDS = 3 * VERTEX_STRIDE;
    localparam int AREA_W    = 2 * COORD_W + 2;
    localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_SETUP, S_CLIP, S_TRAVERSE, S_NEXT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]               remaining;
    logic [ADDR_W-1:0]         base;
    logic [2:0]                fetch_cnt;
    logic [1:0]                cull_q;
    logic [COLOR_W-1:0]        clear_color_q;
    logic [COLOR_W-1:0]        tri_color;
    logic                      aborted_q;
    logic signed [AREA_W-1:0]  area;
    logic signed [COORD_W-1:0] bb_min_x, bb_max_x, bb_min_y, bb_max_y;
    logic signed [COORD_W-1:0] x_lo, x_hi, y_lo, y_hi;

    logic                      abort_hit, xfer, last_px, reject, culled_by_mode, offscreen;
    logic signed [COORD_W-1:0] fetched;
    logic signed [AREA_W-1:0]  dx21, dy21, dx31, dy31, area_calc;

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Word k of a triangle: vertex k/2, x when k is even, y when odd.
    function automatic logic [ADDR_W-1:0] word_offset(input logic [2:0] k);
        return ADDR_W'(k[2:1]) * ADDR_W'(VERTEX_STRIDE) + ADDR_W'(k[0]);
    endfunction

    assign px_valid = (state == S_CLEAR) || (state == S_TRAVERSE);
    assign px_clear = (state == S_CLEAR);
    assign px_color = px_clear ? clear_color_q : tri_color;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign aborted  = done && aborted_q;

    assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);
    assign xfer      = px_valid && px_ready && !abort_hit;
    assign last_px   = (px_x == x_hi) && (px_y == y_hi);
    // Odd fetch cycles return x words, even ones y words.
    assign fetched   = mem_rdata + (fetch_cnt[0] ? COORD_W'(ORIGIN_X) : COORD_W'(ORIGIN_Y));

    always_comb begin
        dx21      = AREA_W'(v2_x) - AREA_W'(v1_x);
        dy21      = AREA_W'(v2_y) - AREA_W'(v1_y);
        dx31      = AREA_W'(v3_x) - AREA_W'(v1_x);
        dy31      = AREA_W'(v3_y) - AREA_W'(v1_y);
        area_calc = dx21 * dy31 - dy21 * dx31;
    end

    always_comb begin
        culled_by_mode = 1'b0;
        case (cull_q)
            2'd1:    culled_by_mode = (area < 0);
            2'd2:    culled_by_mode = (area > 0);
            default: culled_by_mode = 1'b0;
        endcase
        offscreen = (bb_max_x < 0) || (bb_max_y < 0) || (bb_min_x > X_MAX) || (bb_min_y > Y_MAX);
        reject    = (area == '0) || culled_by_mode || offscreen;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = clear_en ? S_CLEAR : S_NEXT;
            S_CLEAR:    if (xfer && last_px) state_nxt = S_NEXT;
            S_NEXT:     state_nxt = (remaining >= 32'(TRI_WORDS)) ? S_FETCH : S_DONE;
            S_FETCH:    if (fetch_cnt == 3'd6) state_nxt = S_SETUP;
            S_SETUP:    state_nxt = S_CLIP;
            S_CLIP:     state_nxt = reject ? S_NEXT : S_TRAVERSE;
            S_TRAVERSE: if (xfer && last_px) state_nxt = S_NEXT;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_DONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining     <= '0;
            base          <= '0;
            fetch_cnt     <= '0;
            cull_q        <= '0;
            clear_color_q <= '0;
            tri_color     <= '0;
            aborted_q     <= 1'b0;
            area          <= '0;
            bb_min_x      <= '0;
            bb_max_x      <= '0;
            bb_min_y      <= '0;
            bb_max_y      <= '0;
            x_lo          <= '0;
            x_hi          <= '0;
            y_lo          <= '0;
            y_hi          <= '0;
            mem_addr      <= '0;
            px_x          <= '0;
            px_y          <= '0;
            v1_x          <= '0;
            v1_y          <= '0;
            v2_x          <= '0;
            v2_y          <= '0;
            v3_x          <= '0;
            v3_y          <= '0;
            tri_drawn     <= '0;
            tri_culled    <= '0;
        end else if (abort_hit) begin
            aborted_q <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    remaining     <= vertex_count;
                    base          <= '0;
                    mem_addr      <= '0;
                    tri_drawn     <= '0;
                    tri_culled    <= '0;
                    tri_color     <= base_color;
                    clear_color_q <= clear_color;
                    cull_q        <= cull_mode;
                    aborted_q     <= 1'b0;
                    x_lo          <= '0;
                    x_hi          <= X_MAX;
                    y_lo          <= '0;
                    y_hi          <= Y_MAX;
                    px_x          <= '0;
                    px_y          <= '0;
                end
                S_CLEAR, S_TRAVERSE: if (xfer) begin
                    if (px_x == x_hi) begin
                        px_x <= x_lo;
                        px_y <= px_y + COORD_W'(1);
                    end else begin
                        px_x <= px_x + COORD_W'(1);
                    end
                    if (last_px && state == S_TRAVERSE) tri_color <= tri_color + COLOR_W'(1);
                end
                S_NEXT: begin
                    mem_addr  <= base;
                    fetch_cnt <= '0;
                end
                S_FETCH: begin
                    fetch_cnt <= fetch_cnt + 3'd1;
                    if (fetch_cnt < 3'd5) mem_addr <= base + word_offset(fetch_cnt + 3'd1);
                    case (fetch_cnt)
                        3'd1:    v1_x <= fetched;
                        3'd2:    v1_y <= fetched;
                        3'd3:    v2_x <= fetched;
                        3'd4:    v2_y <= fetched;
                        3'd5:    v3_x <= fetched;
                        3'd6:    v3_y <= fetched;
                        default: ;
                    endcase
                    if (fetch_cnt == 3'd6) begin
                        base      <= base + ADDR_W'(TRI_WORDS);
                        remaining <= remaining - 32'(TRI_WORDS);
                    end
                end
                S_SETUP: begin
                    area     <= area_calc;
                    bb_min_x <= min3(v1_x, v2_x, v3_x);
                    bb_max_x <= max3(v1_x, v2_x, v3_x);
                    bb_min_y <= min3(v1_y, v2_y, v3_y);
                    bb_max_y <= max3(v1_y, v2_y, v3_y);
                end
                S_CLIP: begin
                    if (reject) begin
                        if (tri_culled != '1) tri_culled <= tri_culled + 16'd1;
                    end else begin
                        x_lo <= (bb_min_x < 0) ? '0 : bb_min_x;
                        y_lo <= (bb_min_y < 0) ? '0 : bb_min_y;
                        x_hi <= (bb_max_x > X_MAX) ? X_MAX : bb_max_x;
                        y_hi <= (bb_max_y > Y_MAX) ? Y_MAX : bb_max_y;
                        px_x <= (bb_min_x < 0) ? '0 : bb_min_x;
                        px_y <= (bb_min_y < 0) ? '0 : bb_min_y;
                        if (tri_drawn != '1) tri_drawn <= tri_drawn + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_traversal_ctrl.sv
// Self-checking bench for raster_traversal_ctrl on a reduced 64x48 screen: directed
// scenarios plus randomized frames, all checked against a pixel-list reference model.
module tb_raster_traversal_ctrl;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int OX = 32;
    localparam int OY = 24;
    localparam int S  = 4;
    localparam int TW = 3 * S;
    localparam int CW = 11;
    localparam int BUDGET = 30000;

    typedef struct {
        int          x;
        int          y;
        bit          clr;
        int          color;
        logic [65:0] verts;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, start, abort, clear_en, px_ready;
    logic [31:0]          vertex_count;
    logic [7:0]           clear_color, base_color;
    logic [1:0]           cull_mode;
    logic [13:0]          mem_addr;
    logic signed [CW-1:0] mem_rdata;
    logic                 px_valid, px_clear, busy, done, aborted;
    logic signed [CW-1:0] px_x, px_y, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;
    logic [7:0]           px_color;
    logic [15:0]          tri_drawn, tri_culled;

    raster_traversal_ctrl #(
        .SCREEN_W(W), .SCREEN_H(H), .COORD_W(CW), .ADDR_W(14),
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .VERTEX_STRIDE(S), .COLOR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .vertex_count(vertex_count), .clear_en(clear_en), .clear_color(clear_color),
        .base_color(base_color), .cull_mode(cull_mode), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .px_valid(px_valid), .px_ready(px_ready),
        .px_x(px_x), .px_y(px_y), .px_clear(px_clear), .px_color(px_color),
        .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y), .v3_x(v3_x), .v3_y(v3_y),
        .busy(busy), .done(done), .aborted(aborted),
        .tri_drawn(tri_drawn), .tri_culled(tri_culled)
    );

    logic signed [CW-1:0] mem [0:16383];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    int          exp_drawn, exp_culled;
    int          beat_cnt;
    logic [21:0] first_xy, last_xy;
    bit          stall_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [127:0] snap = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_tri(input int t, input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3);
        int b;
        b = t * TW;
        mem[b]       = CW'(x1);
        mem[b+1]     = CW'(y1);
        mem[b+S]     = CW'(x2);
        mem[b+S+1]   = CW'(y2);
        mem[b+2*S]   = CW'(x3);
        mem[b+2*S+1] = CW'(y3);
    endtask

    // Reference: the full ordered pixel list of a frame plus its triangle counters.
    task automatic build_model(input int vcount, input bit clr, input int ccol, input int bcol,
                               input int cull);
        int rem, base, col, area, minx, maxx, miny, maxy;
        int vx[3], vy[3];
        beat_t b;
        exp_q.delete();
        exp_drawn  = 0;
        exp_culled = 0;
        if (clr) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    b.x = x; b.y = y; b.clr = 1'b1; b.color = ccol; b.verts = '0;
                    exp_q.push_back(b);
                end
        end
        rem  = vcount;
        base = 0;
        col  = bcol;
        while (rem >= TW) begin
            for (int k = 0; k < 3; k++) begin
                vx[k] = int'(mem[base + k*S]) + OX;
                vy[k] = int'(mem[base + k*S + 1]) + OY;
            end
            base += TW;
            rem  -= TW;
            area = (vx[1]-vx[0])*(vy[2]-vy[0]) - (vy[1]-vy[0])*(vx[2]-vx[0]);
            minx = vx[0]; maxx = vx[0]; miny = vy[0]; maxy = vy[0];
            for (int k = 1; k < 3; k++) begin
                if (vx[k] < minx) minx = vx[k];
                if (vx[k] > maxx) maxx = vx[k];
                if (vy[k] < miny) miny = vy[k];
                if (vy[k] > maxy) maxy = vy[k];
            end
            if (area == 0 || (cull == 1 && area < 0) || (cull == 2 && area > 0) ||
                maxx < 0 || maxy < 0 || minx > W-1 || miny > H-1) begin
                exp_culled++;
            end else begin
                if (minx < 0) minx = 0;
                if (miny < 0) miny = 0;
                if (maxx > W-1) maxx = W-1;
                if (maxy > H-1) maxy = H-1;
                exp_drawn++;
                for (int y = miny; y <= maxy; y++)
                    for (int x = minx; x <= maxx; x++) begin
                        b.x = x; b.y = y; b.clr = 1'b0; b.color = col;
                        b.verts = {CW'(vx[0]), CW'(vy[0]), CW'(vx[1]), CW'(vy[1]),
                                   CW'(vx[2]), CW'(vy[2])};
                        exp_q.push_back(b);
                    end
                col = (col + 1) % 256;
            end
        end
    endtask

    // Pixel monitor and stall-stability checker, sampling mid-cycle.
    always @(negedge clk) begin : monitor
        beat_t        e;
        logic [127:0] now;
        now = {px_valid, px_x, px_y, px_clear, px_color, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y};
        if (prev_stall) check("stall_hold", now, snap);
        if (px_valid && px_ready && !abort && !reset) begin
            if (beat_cnt == 0) first_xy = {px_x, px_y};
            last_xy = {px_x, px_y};
            beat_cnt++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pixel", {px_x, px_y, px_clear, px_color},
                      {CW'(e.x), CW'(e.y), e.clr, 8'(e.color)});
                if (!e.clr) check("verts", {v1_x, v1_y, v2_x, v2_y, v3_x, v3_y}, e.verts);
            end
        end
        prev_stall = px_valid && !px_ready && !abort && !reset;
        snap       = now;
    end

    initial begin
        px_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            px_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic pulse_start(input int vcount, input bit clr, input int ccol, input int bcol,
                               input int cull);
        @(posedge clk);
        #1;
        vertex_count = 32'(vcount);
        clear_en     = clr;
        clear_color  = 8'(ccol);
        base_color   = 8'(bcol);
        cull_mode    = 2'(cull);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int vcount, input bit clr, input int ccol, input int bcol,
                             input int cull, input bit poke);
        int n_exp, cyc;
        build_model(vcount, clr, ccol, bcol, cull);
        n_exp    = exp_q.size();
        beat_cnt = 0;
        pulse_start(vcount, clr, ccol, bcol, cull);
        cyc = 0;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 20 && busy && !done) begin
                start        = 1'b1;
                vertex_count = '0;
                clear_en     = ~clr;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        check("done_seen", done, 1);
        check("aborted_low", aborted, 0);
        check("tri_drawn", tri_drawn, 16'(exp_drawn));
        check("tri_culled", tri_culled, 16'(exp_culled));
        check("beat_count", beat_cnt, n_exp);
        check("leftover", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", {busy, done}, 2'b00);
        exp_q.delete();
    endtask

    initial begin
        int cyc, ntri, vc;
        reset = 1'b1; start = 1'b0; abort = 1'b0; clear_en = 1'b0;
        vertex_count = '0; clear_color = '0; base_color = '0; cull_mode = '0;
        beat_cnt = 0; first_xy = '0; last_xy = '0;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {px_valid, busy, done, aborted, tri_drawn, tri_culled, mem_addr,
                              px_x, px_y, px_clear, px_color}, '0);
        check("reset_verts", {v1_x, v1_y, v2_x, v2_y, v3_x, v3_y}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // abort in IDLE is ignored
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("idle_abort", {busy, done, aborted}, 3'b000);

        // too few words, no clear: done two cycles after start
        @(posedge clk); #1; vertex_count = 32'd5; clear_en = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); check("lat_c1", {busy, done}, 2'b10);
        @(negedge clk); check("lat_c2", {done, aborted}, 2'b10);
        @(negedge clk); check("lat_c3", {busy, done}, 2'b00);

        // one triangle, 441 pixels
        put_tri(0, -10, -10, 10, -10, -10, 10);
        run_frame(12, 0, 0, 8'h3c, 0, 0);
        check("t1_count", beat_cnt, 441);
        check("t1_first", first_xy, {11'd22, 11'd14});
        check("t1_last", last_xy, {11'd42, 11'd34});

        // same triangle under random stalls
        stall_en = 1'b1;
        run_frame(12, 0, 0, 8'h3c, 0, 1);
        check("t5_count", beat_cnt, 441);
        stall_en = 1'b0;

        // swapped winding: culled as back face, kept when culling front faces
        put_tri(0, -10, -10, -10, 10, 10, -10);
        run_frame(12, 0, 0, 8'h10, 1, 0);
        check("back_cull_beats", beat_cnt, 0);
        run_frame(12, 0, 0, 8'h10, 2, 0);
        check("front_cull_beats", beat_cnt, 441);

        // clear pass only
        run_frame(0, 1, 8'h55, 8'h01, 0, 0);
        check("clear_count", beat_cnt, W * H);
        check("clear_last", last_xy, {11'(W-1), 11'(H-1)});

        // fully offscreen rejection, then a triangle clamped on the right edge
        put_tri(0, -500, -10, -450, -10, -450, 10);
        put_tri(1, 20, -10, 60, -10, 20, 10);
        run_frame(24, 0, 0, 8'hfe, 0, 0);
        check("clamp_count", beat_cnt, 12 * 21);
        check("clamp_first", first_xy, {11'd52, 11'd14});
        check("clamp_last", last_xy, {11'd63, 11'd34});

        // abort after 100 pixels
        put_tri(0, -10, -10, 10, -10, -10, 10);
        build_model(12, 0, 0, 8'h3c, 0);
        beat_cnt = 0;
        pulse_start(12, 0, 0, 8'h3c, 0);
        cyc = 0;
        while (beat_cnt < 100 && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
        end
        check("abort_reach", beat_cnt, 100);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort_valid", px_valid, 0);
        check("abort_done", {done, aborted}, 2'b11);
        check("abort_drawn", tri_drawn, 16'd1);
        check("abort_beats", beat_cnt, 100);
        @(negedge clk);
        check("abort_idle", {busy, done, aborted}, 3'b000);
        exp_q.delete();

        // reset mid-frame
        build_model(12, 0, 0, 8'h3c, 0);
        beat_cnt = 0;
        pulse_start(12, 0, 0, 8'h3c, 0);
        cyc = 0;
        while (beat_cnt < 50 && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset_state", {px_valid, busy, done, aborted, tri_drawn, tri_culled, mem_addr,
                                 px_x, px_y, px_color}, '0);
        reset = 1'b0;
        exp_q.delete();

        // randomized frames
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 64; i++) mem[i] = '0;
            ntri = $urandom_range(1, 3);
            for (int t = 0; t < ntri; t++)
                put_tri(t, $urandom_range(0, 70) - 30, $urandom_range(0, 70) - 30,
                        $urandom_range(0, 70) - 30, $urandom_range(0, 70) - 30,
                        $urandom_range(0, 70) - 30, $urandom_range(0, 70) - 30);
            vc       = ntri * TW + $urandom_range(0, TW - 1);
            stall_en = ($urandom_range(0, 1) == 1);
            run_frame(vc, (f == 2), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 3), (f % 2 == 1));
        end
        stall_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/raster_traversal_ctrl.md
Name: raster_traversal_ctrl

Overview:
- Parametrised triangle setup and traversal controller. Successor to the fixed 800x600 rasterizer control path.
- Fetches triangle vertices from a vertex BRAM and computes signed area, culling and clipped bounding box.
- Streams pixel coordinates plus triangle vertices to the downstream inside-test/pixel unit over valid/ready.
- Adds an optional clear pass with programmable colour, back/front-face culling, full-offscreen rejection, abort, and statistics counters.

Parameters:
- SCREEN_W, 800, horizontal resolution in pixels
- SCREEN_H, 600, vertical resolution in pixels
- COORD_W, 11, signed coordinate width (memory word and screen coordinates)
- ADDR_W, 14, vertex memory address width
- ORIGIN_X, 400, added to every fetched x
- ORIGIN_Y, 300, added to every fetched y
- VERTEX_STRIDE, 4, words between consecutive vertices; x at +0, y at +1; TRI_WORDS = 3*VERTEX_STRIDE
- COLOR_W, 8, colour width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame (ignored unless IDLE)
- abort  in  1  terminate the frame
- vertex_count  in  32  words in the buffer, sampled at start
- clear_en  in  1  run the clear pass first, sampled at start
- clear_color  in  COLOR_W  clear-pass colour, sampled at start
- base_color  in  COLOR_W  first triangle colour, sampled at start
- cull_mode  in  2  0 none, 1 cull back (area<0), 2 cull front (area>0), 3 treated as 0
- mem_addr  out  ADDR_W  vertex BRAM address
- mem_rdata  in  COORD_W signed  read data, 1-cycle latency
- px_valid  out  1  pixel valid
- px_ready  in  1  downstream ready
- px_x, px_y  out  COORD_W  pixel coordinate
- px_clear  out  1  pixel belongs to the clear pass (draw unconditionally)
- px_color  out  COLOR_W  pixel colour
- v1_x, v1_y, v2_x, v2_y, v3_x, v3_y  out  COORD_W signed  current triangle, origin applied
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on frame end
- aborted  out  1  valid with done; frame ended by abort
- tri_drawn  out  16  triangles traversed this frame, saturating
- tri_culled  out  16  triangles rejected this frame (cull, zero area, offscreen), saturating

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, CLEAR, FETCH, SETUP, CLIP, TRAVERSE, NEXT, DONE.
- IDLE, start=1:
  - Latch inputs; mem_addr=0; clear tri_drawn and tri_culled; colour = base_color.
  - Go to CLEAR if clear_en, else NEXT.
- CLEAR:
  - Raster over 0..SCREEN_W-1 x 0..SCREEN_H-1 with px_clear=1 and px_color=clear_color.
  - After the last pixel transfers, go to NEXT.
- NEXT:
  - If remaining >= TRI_WORDS, go to FETCH; else go to DONE.
  - remaining starts at vertex_count and drops by TRI_WORDS per triangle.
- FETCH: exactly 7 cycles.
  - Issue addresses base+0, +1, +S, +S+1, +2S, +2S+1 (S = VERTEX_STRIDE).
  - Capture each word one cycle after its address, adding ORIGIN_X or ORIGIN_Y.
  - On exit: base += TRI_WORDS, remaining -= TRI_WORDS.
- SETUP: one cycle.
  - area = (x2-x1)*(y3-y1) - (y2-y1)*(x3-x1), computed signed at 2*COORD_W+2 bits.
  - Compute bbox min and max of the three vertices.
- CLIP: one cycle.
  - Reject if area==0, culled by mode, or bbox fully offscreen (max_x<0, max_y<0, min_x>SCREEN_W-1 or min_y>SCREEN_H-1).
  - On reject: tri_culled+1, go to NEXT.
  - Otherwise clamp bbox to the screen, tri_drawn+1, go to TRAVERSE.
- TRAVERSE: row-major from (min_x, min_y) to (max_x, max_y), same raster as CLEAR.
  - px_clear=0; px_color = triangle colour.
  - After the last pixel transfers: colour+1 (wraps), go to NEXT.
- Handshake (CLEAR and TRAVERSE):
  - px_valid=1 in these states.
  - Transfer when px_valid && px_ready; the coordinate advances only on a transfer.
  - All px_* and v* outputs stay stable while px_valid && !px_ready.
  - No bubbles between consecutive pixels of one pass.
- DONE: done=1 for one cycle, aborted=0, then IDLE. Counters hold until the next start.
- Abort, in any non-IDLE state:
  - Next cycle is DONE with aborted=1; px_valid is 0 from that cycle.
  - An in-flight beat is dropped.
  - abort takes priority over every other transition.
  - abort in IDLE is ignored.
- start while busy is ignored.
- reset mid-frame returns to the reset values immediately.
- vertex_count < TRI_WORDS with clear_en=0: done pulses 2 cycles after start.

Test Plan:
- Defaults, one triangle, words (-10,-10),(10,-10),(-10,10), vertex_count=12, px_ready=1, no clear -> 441 pixels (390..410 x 290..310) in row-major order, px_color=base_color, tri_drawn=1, done pulses.
- Same triangle with v2 and v3 swapped (area<0): cull_mode=1 -> 0 pixels, tri_culled=1; cull_mode=2 -> 441 pixels.
- clear_en=1, clear_color=0x55, vertex_count=0 -> 480000 pixels with px_clear=1, last at (799,599), then done.
- Triangle (-500,-10),(-450,-10),(-450,10) -> rejected as offscreen, tri_culled=1. Triangle (390,-10),(500,-10),(390,10) -> x clamped to 790..799.
- Random px_ready stalls on the first test -> identical 441-pixel sequence, outputs stable while stalled.
- abort at pixel 100 -> px_valid low next cycle, done with aborted=1, tri_drawn=1.
